brush_stamper: RTL

- Drawing-engine stage directly upstream of the pixel frame store.
- Accepts one paint command per valid/ready handshake: a centred square stamp, or a full-screen fill.
- Expands the command into a raster-ordered stream of single-pixel writes, one per clock, on the store's write port (brush, wx, wy, newColor).
- Clips every stamp to the visible screen, so the store never sees an out-of-range coordinate.

---
 rtl/paint_pkg.sv | 42 ++++
 rtl/brush_stamper_if.sv | 28 ++
 rtl/brush_bounds.sv | 27 ++
 rtl/brush_stamper.sv | 82 ++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared types and screen geometry for the paint pipeline (stamper, frame store, display).
package paint_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [2:0]         color_t;
  typedef logic [2:0]         size_t;

  typedef enum logic {IDLE, STAMP} state_t;

  localparam coord_t X_LIM = coord_t'(SCREEN_W);
  localparam coord_t Y_LIM = coord_t'(SCREEN_H);
  localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

  typedef struct packed {
    coord_t x0;
    coord_t x1;
    coord_t y0;
    coord_t y1;
    logic   off_screen;
  } bounds_t;

  // Lower stamp edge, clamped at 0; one extra bit keeps c-s from wrapping.
  function automatic coord_t lo_clip(input coord_t c, input size_t s);
    logic [COORD_W:0] ce;
    logic [COORD_W:0] se;
    ce = {1'b0, c};
    se = {{(COORD_W-2){1'b0}}, s};
    return (ce < se) ? '0 : coord_t'(ce - se);
  endfunction

  function automatic coord_t hi_clip(input coord_t c, input size_t s, input coord_t lim);
    logic [COORD_W:0] sum;
    sum = {1'b0, c} + {{(COORD_W-2){1'b0}}, s};
    return (sum > {1'b0, lim}) ? lim : coord_t'(sum);
  endfunction

endpackage

// File: rtl/brush_stamper_if.sv
// Command handshake plus frame-store write port of the brush stamper.
interface brush_stamper_if;
  import paint_pkg::*;

  logic   cmd_valid;
  logic   cmd_ready;
  logic   cmd_fill;
  coord_t cmd_x;
  coord_t cmd_y;
  size_t  cmd_size;
  color_t cmd_color;
  logic   brush;
  coord_t wx;
  coord_t wy;
  color_t newColor;
  logic   busy;

  modport master (
    output cmd_valid, cmd_fill, cmd_x, cmd_y, cmd_size, cmd_color,
    input  cmd_ready, brush, wx, wy, newColor, busy
  );

  modport slave (
    input  cmd_valid, cmd_fill, cmd_x, cmd_y, cmd_size, cmd_color,
    output cmd_ready, brush, wx, wy, newColor, busy
  );

endinterface

// File: rtl/brush_bounds.sv
// Clipped raster window for a paint command; fill covers the whole screen.
module brush_bounds
  import paint_pkg::*;
(
  input  logic    fill,
  input  coord_t  x,
  input  coord_t  y,
  input  size_t   size,
  output bounds_t bounds
);

  always_comb begin
    if (fill) begin
      bounds.x0 = '0;
      bounds.x1 = X_MAX;
      bounds.y0 = '0;
      bounds.y1 = Y_MAX;
    end else begin
      bounds.x0 = lo_clip(x, size);
      bounds.x1 = hi_clip(x, size, X_MAX);
      bounds.y0 = lo_clip(y, size);
      bounds.y1 = hi_clip(y, size, Y_MAX);
    end
    bounds.off_screen = !fill && ((x >= X_LIM) || (y >= Y_LIM));
  end

endmodule

// File: rtl/brush_stamper.sv
// Expands stamp/fill commands into one clipped pixel write per clock, in raster order.
module brush_stamper
  import paint_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  brush_stamper_if.slave bus
);

  bounds_t bnd;
  state_t  state;
  logic    brush_q;
  logic    busy_q;
  coord_t  wx_q;
  coord_t  wy_q;
  coord_t  x0_q;
  coord_t  x1_q;
  coord_t  y1_q;
  color_t  color_q;

  brush_bounds u_bounds (
    .fill   (bus.cmd_fill),
    .x      (bus.cmd_x),
    .y      (bus.cmd_y),
    .size   (bus.cmd_size),
    .bounds (bnd)
  );

  // NOTE: every register below uses non-blocking assignment so all updates
  // within an edge see the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      brush_q <= 1'b0;
      busy_q  <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Off-screen commands are consumed here with no writes at all.
          if (bus.cmd_valid && !bnd.off_screen) begin
            state   <= STAMP;
            brush_q <= 1'b1;
            busy_q  <= 1'b1;
            wx_q    <= bnd.x0;
            wy_q    <= bnd.y0;
            x0_q    <= bnd.x0;
            x1_q    <= bnd.x1;
            y1_q    <= bnd.y1;
            color_q <= bus.cmd_color;
          end
        end
        STAMP: begin
          if (wx_q < x1_q) begin
            wx_q <= wx_q + 1'b1;
          end else if (wy_q < y1_q) begin
            wx_q <= x0_q;
            wy_q <= wy_q + 1'b1;
          end else begin
            state   <= IDLE;
            brush_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.brush     = brush_q;
  assign bus.busy      = busy_q;
  assign bus.wx        = wx_q;
  assign bus.wy        = wy_q;
  assign bus.newColor  = color_q;

endmodule
